// File: rtl/writeback_unit.sv
// Writeback stage feeding the register file write port.
// Merges ALU results with in-order load responses, tracks outstanding loads
// in a small tag FIFO, aligns/extends load data, and exports a busy_mask so
// issue logic can stall on registers that still have a load in flight.
module writeback_unit #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue,
    output logic            ld_issue_ready,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_offset,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            reg_write,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] data,
    output logic [31:0]     busy_mask,
    output logic            proto_err
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(LQ_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0] CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Load-type encodings (RV32I funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Tag FIFO storage; only the valid bits need reset.
    logic [4:0]       tag_rd_reg  [LQ_DEPTH];
    logic [2:0]       tag_f3_reg  [LQ_DEPTH];
    logic [1:0]       tag_off_reg [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] valid_reg;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W:0]   count_next;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic orphan;
    logic alu_fire;

    // Head tag fields and aligned load result
    logic [4:0]      head_rd;
    logic [2:0]      head_f3;
    logic [1:0]      head_off;
    logic [XLEN-1:0] shifted_word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_aligned;

    // Per-entry contribution to busy_mask
    logic [31:0] entry_mask [LQ_DEPTH];

    assign fifo_full      = (count_reg == FULL_COUNT);
    assign fifo_empty     = (count_reg == '0);
    assign ld_issue_ready = !fifo_full;

    // A full FIFO drops the issue; memory responses are never stalled.
    assign push   = ld_issue && !fifo_full;
    assign pop    = mem_rvalid && !fifo_empty;
    assign orphan = mem_rvalid && fifo_empty;

    // Loads own the write port whenever a response arrives; an ALU result
    // to a register with a pending load must wait so writes stay in order.
    assign alu_ready = !mem_rvalid && !busy_mask[alu_rd];
    assign alu_fire  = alu_valid && alu_ready;

    assign head_rd  = tag_rd_reg[rd_ptr_reg];
    assign head_f3  = tag_f3_reg[rd_ptr_reg];
    assign head_off = tag_off_reg[rd_ptr_reg];

    // Each valid entry marks its destination register busy.
    generate
        for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_entry_mask
            assign entry_mask[gi] = valid_reg[gi] ? (32'd1 << tag_rd_reg[gi]) : 32'd0;
        end
    endgenerate

    // OR all entry masks; x0 is never reported busy.
    always_comb begin
        busy_mask = 32'd0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            busy_mask = busy_mask | entry_mask[i];
        end
        busy_mask[0] = 1'b0;
    end

    // Select the addressed byte/half of the response word and extend it.
    always_comb begin
        shifted_word = mem_rdata >> {head_off, 3'b000};
        ld_byte      = shifted_word[7:0];
        ld_half      = head_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (head_f3)
            F3_LB:   ld_aligned = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_aligned = {{(XLEN-8){1'b0}}, ld_byte};
            F3_LH:   ld_aligned = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_LHU:  ld_aligned = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_aligned = mem_rdata;
        endcase
    end

    // Next pointer/count values; simultaneous push and pop keep the count.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        if (push && !pop) begin
            count_next = count_reg + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    // Tag payload write; contents are only meaningful under valid_reg.
    always_ff @(posedge clock) begin
        if (push) begin
            tag_rd_reg[wr_ptr_reg]  <= ld_rd;
            tag_f3_reg[wr_ptr_reg]  <= ld_funct3;
            tag_off_reg[wr_ptr_reg] <= ld_offset;
        end
    end

    // FIFO control state; reset discards every outstanding tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // Push and pop never hit the same slot: push needs !full,
            // pop needs !empty, and the pointers only coincide at those.
            if (push) begin
                valid_reg[wr_ptr_reg] <= 1'b1;
            end
            if (pop) begin
                valid_reg[rd_ptr_reg] <= 1'b0;
            end
        end
    end

    // Registered write port: load pop first, then accepted ALU result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write <= 1'b0;
            rd        <= 5'd0;
            data      <= '0;
        end else if (pop) begin
            reg_write <= (head_rd != 5'd0);
            rd        <= head_rd;
            data      <= ld_aligned;
        end else if (alu_fire) begin
            reg_write <= (alu_rd != 5'd0);
            rd        <= alu_rd;
            data      <= alu_data;
        end else begin
            reg_write <= 1'b0;
        end
    end

    // Sticky flag for a response that had no matching tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (orphan) begin
            proto_err <= 1'b1;
        end
    end

endmodule
